dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 93 +++++++++
 tb/tb_dmem_responder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for a pipelined core: accepts one load/store,
// holds the pipeline via stall for LATENCY cycles, then completes in a DONE cycle.
module dmem_responder #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] adr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_cnt, w_cnt_next;
    logic          w_req, w_accept;
    logic          r_is_wr;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata, r_rdata;
    logic [31:0]   r_mem [DEPTH_WORDS];

    assign w_req = mem_read | mem_write;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_accept   = 1'b1;
                    stall      = 1'b1;
                    w_cnt_next = 4'(LATENCY - 1);
                    // With a single wait cycle the accept cycle is the only stall cycle.
                    w_next     = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall      = 1'b1;
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (rst) begin
            w_accept = 1'b0;
            stall    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_rdata  <= 32'h0;
            rd_count <= 16'h0;
            wr_count <= 16'h0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_is_wr <= mem_write;
                r_idx   <= adr[AW+1:2];
                r_wdata <= write_data;
            end
            if (r_state == DONE) begin
                if (r_is_wr) begin
                    if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                end else begin
                    r_rdata <= r_mem[r_idx];
                    if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                end
            end
        end
    end

    // Storage is never cleared; a reset landing in DONE drops the pending store.
    always_ff @(posedge clk) begin
        if (!rst && r_state == DONE && r_is_wr) r_mem[r_idx] <= r_wdata;
    end

    assign read_data = (r_state == DONE && !r_is_wr) ? r_mem[r_idx] : r_rdata;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stimulus pushes expected completions into a
// queue, a monitor pops and compares each time a DONE cycle is observed.
module tb_dmem_responder;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] adr = 32'h0, write_data = 32'h0;
    logic [31:0] read_data;
    logic        stall;
    logic [15:0] rd_count, wr_count;

    dmem_responder #(.LATENCY(LATENCY), .DEPTH_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .adr(adr), .write_data(write_data), .read_data(read_data),
        .stall(stall), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [15:0] rc;
        logic [15:0] wc;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0, bad = 0;
    logic [15:0] m_rc = 16'h0, m_wc = 16'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One access; exp_rd is the value read_data must show in the DONE cycle.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input bit scramble);
        exp_t e;
        bit   done;
        if (wr) begin
            if (m_wc != 16'hFFFF) m_wc++;
        end else if (m_rc != 16'hFFFF) m_rc++;
        e.rdata = exp_rd; e.rc = m_rc; e.wc = m_wc;
        sbq.push_back(e);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; adr = a; write_data = d;
        @(posedge clk); #1;
        if (scramble) begin
            adr = a ^ 32'h44; write_data = ~d;
        end
        done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!stall) begin done = 1'b1; break; end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL access_timeout: stall still %b expected 0", stall);
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin : mon
        int   streak;
        bit   prev_st;
        exp_t e;
        streak = 0; prev_st = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                streak = 0; prev_st = 1'b0;
            end else if (stall) begin
                streak++; prev_st = 1'b1;
            end else begin
                if (prev_st) begin
                    if (sbq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_done: queue size %0d expected >0", sbq.size());
                    end else begin
                        e = sbq.pop_front();
                        chk("stall_cycles", 32'(streak), 32'(LATENCY));
                        chk("read_data", read_data, e.rdata);
                        @(negedge clk);
                        chk("rd_count", {16'h0, rd_count}, {16'h0, e.rc});
                        chk("wr_count", {16'h0, wr_count}, {16'h0, e.wc});
                    end
                end
                streak = 0; prev_st = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", {31'h0, stall}, 32'h0);
        chk("reset_read_data", read_data, 32'h0);
        chk("reset_rd_count", {16'h0, rd_count}, 32'h0);
        chk("reset_wr_count", {16'h0, wr_count}, 32'h0);

        // store/load, address wrap, simultaneous read+write, byte offset ignored
        access(0, 1, 32'h10,   32'hDEADBEEF, 32'h0,        0);
        access(1, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0);
        access(0, 1, 32'h1000, 32'h12345678, 32'hDEADBEEF, 0);
        access(1, 0, 32'h0,    32'h0,        32'h12345678, 0);
        access(1, 1, 32'h20,   32'hA5A5A5A5, 32'h12345678, 0);
        access(1, 0, 32'h20,   32'h0,        32'hA5A5A5A5, 0);
        access(1, 0, 32'h23,   32'h0,        32'hA5A5A5A5, 0);

        // reset in the BUSY cycle of a store aborts it
        access(0, 1, 32'h40, 32'h11111111, 32'hA5A5A5A5, 0);
        @(posedge clk); #1;
        mem_write = 1'b1; adr = 32'h40; write_data = 32'h22222222;
        @(posedge clk); #1;
        rst = 1'b1; mem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_stall", {31'h0, stall}, 32'h0);
        chk("abort_rd_count", {16'h0, rd_count}, 32'h0);
        chk("abort_wr_count", {16'h0, wr_count}, 32'h0);
        chk("abort_read_data", read_data, 32'h0);
        m_rc = 16'h0; m_wc = 16'h0;
        access(1, 0, 32'h40, 32'h0, 32'h11111111, 0);

        // reset wins over a simultaneous request
        @(posedge clk); #1;
        rst = 1'b1; mem_read = 1'b1; adr = 32'h10;
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        chk("rst_dominates_stall", {31'h0, stall}, 32'h0);
        chk("rst_dominates_rd_count", {16'h0, rd_count}, 32'h0);
        m_rc = 16'h0; m_wc = 16'h0;

        // inputs changed during BUSY must not affect the latched access
        access(0, 1, 32'h80, 32'hCAFEF00D, 32'h0, 1);
        access(1, 0, 32'h80, 32'h0, 32'hCAFEF00D, 0);

        // store counter saturation
        @(posedge clk); #1;
        force dut.wr_count = 16'hFFFF;
        #2 release dut.wr_count;
        m_wc = 16'hFFFF;
        access(0, 1, 32'h100, 32'h0BADF00D, 32'hCAFEF00D, 0);
        access(1, 0, 32'h100, 32'h0, 32'h0BADF00D, 0);

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(sbq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
